// File: rtl/axi_llc_wr_mux.sv
// axi_llc_wr_mux: N-to-1 AXI4 write-path mux in front of the LLC (round-robin AW, W in grant order, B by ID).
// Define AXI_LLC_WR_MUX_AW_BYPASS_EN for a combinational 0-latency AW path; otherwise AW is registered.
module axi_llc_wr_mux #(
    parameter int NumPorts     = 4,
    parameter int AxiIdWidth   = 6,
    parameter int AxiAddrWidth = 64,
    parameter int AxiDataWidth = 64,
    parameter int WFifoDepth   = 4,
    localparam int PortIdxW    = $clog2(NumPorts),
    localparam int MstIdW      = AxiIdWidth + PortIdxW
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumPorts-1:0]                slv_aw_valid_i,
    output logic [NumPorts-1:0]                slv_aw_ready_o,
    input  logic [NumPorts*AxiIdWidth-1:0]     slv_aw_id_i,
    input  logic [NumPorts*AxiAddrWidth-1:0]   slv_aw_addr_i,
    input  logic [NumPorts-1:0]                slv_w_valid_i,
    output logic [NumPorts-1:0]                slv_w_ready_o,
    input  logic [NumPorts*AxiDataWidth-1:0]   slv_w_data_i,
    input  logic [NumPorts-1:0]                slv_w_last_i,
    output logic [NumPorts-1:0]                slv_b_valid_o,
    input  logic [NumPorts-1:0]                slv_b_ready_i,
    output logic [AxiIdWidth-1:0]              slv_b_id_o,
    output logic                               mst_aw_valid_o,
    input  logic                               mst_aw_ready_i,
    output logic [MstIdW-1:0]                  mst_aw_id_o,
    output logic [AxiAddrWidth-1:0]            mst_aw_addr_o,
    output logic                               mst_w_valid_o,
    input  logic                               mst_w_ready_i,
    output logic [AxiDataWidth-1:0]            mst_w_data_o,
    output logic                               mst_w_last_o,
    input  logic                               mst_b_valid_i,
    output logic                               mst_b_ready_o,
    input  logic [MstIdW-1:0]                  mst_b_id_i
);

    localparam int SumW = PortIdxW + 1;
    localparam int PtrW = (WFifoDepth > 1) ? $clog2(WFifoDepth) : 1;
    localparam int CntW = $clog2(WFifoDepth + 1);
    localparam logic [PtrW-1:0]     PtrLast  = PtrW'(WFifoDepth - 1);
    localparam logic [CntW-1:0]     CntFull  = CntW'(WFifoDepth);
    localparam logic [PortIdxW-1:0] PortLast = PortIdxW'(NumPorts - 1);

    logic [PortIdxW-1:0] rr_ptr_reg;
    logic [PortIdxW-1:0] arb_idx;
    logic                arb_valid;
    logic [SumW-1:0]     arb_sum;
    logic [PortIdxW-1:0] grant_idx;
    logic                aw_accept;

    logic [PortIdxW-1:0] fifo_mem [WFifoDepth];
    logic [PtrW-1:0]     wr_ptr_reg;
    logic [PtrW-1:0]     rd_ptr_reg;
    logic [CntW-1:0]     count_reg;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;
    logic [PortIdxW-1:0] w_head;

    logic [PortIdxW-1:0] b_idx;
    logic                b_oob;

    // Round-robin search: walk downward so the lowest offset from the pointer wins.
    always_comb begin
        arb_idx   = rr_ptr_reg;
        arb_valid = 1'b0;
        arb_sum   = '0;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            arb_sum = {1'b0, rr_ptr_reg} + SumW'(k);
            if (arb_sum >= SumW'(NumPorts)) begin
                arb_sum = arb_sum - SumW'(NumPorts);
            end
            if (slv_aw_valid_i[arb_sum[PortIdxW-1:0]]) begin
                arb_idx   = arb_sum[PortIdxW-1:0];
                arb_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_reg <= '0;
        end else if (aw_accept) begin
            rr_ptr_reg <= (grant_idx == PortLast) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef AXI_LLC_WR_MUX_AW_BYPASS_EN
    logic                lock_reg;
    logic [PortIdxW-1:0] lock_idx_reg;
    logic                grant_valid;

    // Once offered, the grant is frozen until the LLC takes it; full cannot rise meanwhile.
    assign grant_idx      = lock_reg ? lock_idx_reg : arb_idx;
    assign grant_valid    = (lock_reg | arb_valid) & !fifo_full & !rst_i;
    assign aw_accept      = grant_valid & mst_aw_ready_i;
    assign mst_aw_valid_o = grant_valid;
    assign mst_aw_id_o    = {grant_idx, slv_aw_id_i[grant_idx*AxiIdWidth +: AxiIdWidth]};
    assign mst_aw_addr_o  = slv_aw_addr_i[grant_idx*AxiAddrWidth +: AxiAddrWidth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_reg     <= 1'b0;
            lock_idx_reg <= '0;
        end else begin
            lock_reg     <= grant_valid & !mst_aw_ready_i;
            lock_idx_reg <= grant_idx;
        end
    end
`else
    logic                    aw_valid_reg;
    logic [MstIdW-1:0]       aw_id_reg;
    logic [AxiAddrWidth-1:0] aw_addr_reg;

    assign grant_idx      = arb_idx;
    assign aw_accept      = arb_valid & (!aw_valid_reg | mst_aw_ready_i) & !fifo_full & !rst_i;
    assign mst_aw_valid_o = aw_valid_reg;
    assign mst_aw_id_o    = aw_id_reg;
    assign mst_aw_addr_o  = aw_addr_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_valid_reg <= 1'b0;
            aw_id_reg    <= '0;
            aw_addr_reg  <= '0;
        end else if (aw_accept) begin
            aw_valid_reg <= 1'b1;
            aw_id_reg    <= {arb_idx, slv_aw_id_i[arb_idx*AxiIdWidth +: AxiIdWidth]};
            aw_addr_reg  <= slv_aw_addr_i[arb_idx*AxiAddrWidth +: AxiAddrWidth];
        end else if (mst_aw_ready_i) begin
            aw_valid_reg <= 1'b0;
        end
    end
`endif

    // W order FIFO: holds the port index of every accepted AW whose burst is not yet done.
    assign fifo_full  = (count_reg == CntFull);
    assign fifo_empty = (count_reg == '0);
    assign fifo_push  = aw_accept;
    assign fifo_pop   = mst_w_valid_o & mst_w_ready_i & mst_w_last_o;
    assign w_head     = fifo_mem[rd_ptr_reg];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr_reg <= (wr_ptr_reg == PtrLast) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PtrLast) ? '0 : rd_ptr_reg + 1'b1;
            end
            if (fifo_push && !fifo_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!fifo_push && fifo_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_reg] <= grant_idx;
        end
    end

    assign mst_w_valid_o = !fifo_empty && slv_w_valid_i[w_head];
    assign mst_w_data_o  = slv_w_data_i[w_head*AxiDataWidth +: AxiDataWidth];
    assign mst_w_last_o  = slv_w_last_i[w_head];

    // B responses are routed by the port index carried in the upper ID bits.
    assign b_idx      = mst_b_id_i[MstIdW-1:AxiIdWidth];
    assign slv_b_id_o = mst_b_id_i[AxiIdWidth-1:0];

    if ((1 << PortIdxW) == NumPorts) begin : g_b_pow2
        assign b_oob = 1'b0;
    end else begin : g_b_npow2
        assign b_oob = ({1'b0, b_idx} >= SumW'(NumPorts));
    end

    assign mst_b_ready_o = !rst_i && (b_oob || slv_b_ready_i[b_idx]);

    for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
        assign slv_aw_ready_o[gi] = aw_accept && (grant_idx == PortIdxW'(gi));
        assign slv_w_ready_o[gi]  = !fifo_empty && mst_w_ready_i && (w_head == PortIdxW'(gi));
        assign slv_b_valid_o[gi]  = mst_b_valid_i && !rst_i && !b_oob && (b_idx == PortIdxW'(gi));
    end

endmodule

// File: tb/tb_axi_llc_wr_mux.sv
// tb_axi_llc_wr_mux: directed scenarios plus a randomized run against a queue-based reference model.
module tb_axi_llc_wr_mux;
    localparam int NP    = 4;
    localparam int IDW   = 6;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int PIW   = 2;
    localparam int MIDW  = IDW + PIW;

    typedef struct packed {
        logic [PIW-1:0] port;
        logic           last;
        logic [DW-1:0]  data;
    } beat_t;

    typedef struct packed {
        logic [PIW-1:0] port;
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
    } aw_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NP-1:0]          slv_aw_valid;
    logic [NP-1:0]          slv_aw_ready;
    logic [NP-1:0][IDW-1:0] slv_aw_id;
    logic [NP-1:0][AW-1:0]  slv_aw_addr;
    logic [NP-1:0]          slv_w_valid;
    logic [NP-1:0]          slv_w_ready;
    logic [NP-1:0][DW-1:0]  slv_w_data;
    logic [NP-1:0]          slv_w_last;
    logic [NP-1:0]          slv_b_valid;
    logic [NP-1:0]          slv_b_ready;
    logic [IDW-1:0]         slv_b_id;
    logic                   mst_aw_valid;
    logic                   mst_aw_ready;
    logic [MIDW-1:0]        mst_aw_id;
    logic [AW-1:0]          mst_aw_addr;
    logic                   mst_w_valid;
    logic                   mst_w_ready;
    logic [DW-1:0]          mst_w_data;
    logic                   mst_w_last;
    logic                   mst_b_valid;
    logic                   mst_b_ready;
    logic [MIDW-1:0]        mst_b_id;

    int checks = 0;
    int errors = 0;

    axi_llc_wr_mux #(
        .NumPorts(NP), .AxiIdWidth(IDW), .AxiAddrWidth(AW), .AxiDataWidth(DW), .WFifoDepth(DEPTH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_aw_valid_i(slv_aw_valid), .slv_aw_ready_o(slv_aw_ready),
        .slv_aw_id_i(slv_aw_id), .slv_aw_addr_i(slv_aw_addr),
        .slv_w_valid_i(slv_w_valid), .slv_w_ready_o(slv_w_ready),
        .slv_w_data_i(slv_w_data), .slv_w_last_i(slv_w_last),
        .slv_b_valid_o(slv_b_valid), .slv_b_ready_i(slv_b_ready), .slv_b_id_o(slv_b_id),
        .mst_aw_valid_o(mst_aw_valid), .mst_aw_ready_i(mst_aw_ready),
        .mst_aw_id_o(mst_aw_id), .mst_aw_addr_o(mst_aw_addr),
        .mst_w_valid_o(mst_w_valid), .mst_w_ready_i(mst_w_ready),
        .mst_w_data_o(mst_w_data), .mst_w_last_o(mst_w_last),
        .mst_b_valid_i(mst_b_valid), .mst_b_ready_o(mst_b_ready), .mst_b_id_i(mst_b_id)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        slv_aw_valid = '0;
        slv_aw_id    = '0;
        slv_aw_addr  = '0;
        slv_w_valid  = '0;
        slv_w_data   = '0;
        slv_w_last   = '0;
        slv_b_ready  = '0;
        mst_aw_ready = 1'b1;
        mst_w_ready  = 1'b1;
        mst_b_valid  = 1'b0;
        mst_b_id     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        slv_aw_valid = 4'b0011;
        slv_aw_id[0] = 6'h01;
        slv_aw_id[1] = 6'h02;
        #1;
        checks++; if (slv_aw_ready !== 4'b0001) begin errors++; $display("FAIL reset_pre_aw0 aw_ready=%b exp=%b", slv_aw_ready, 4'b0001); end
        nxt();
        slv_aw_valid = 4'b0010;
        #1;
        checks++; if (slv_aw_ready !== 4'b0010) begin errors++; $display("FAIL reset_pre_aw1 aw_ready=%b exp=%b", slv_aw_ready, 4'b0010); end
        nxt();
        slv_aw_valid  = '0;
        mst_aw_ready  = 1'b0;
        slv_w_valid[0] = 1'b1;
        slv_w_last[0]  = 1'b0;
        slv_w_data[0]  = 64'h1111_2222_3333_4444;
        #1;
        checks++; if (slv_w_ready !== 4'b0001) begin errors++; $display("FAIL reset_pre_w w_ready=%b exp=%b", slv_w_ready, 4'b0001); end
        nxt();
        slv_aw_valid[2] = 1'b1;
        mst_b_valid     = 1'b1;
        mst_b_id        = {2'd1, 6'h0A};
        slv_b_ready     = 4'b1111;
        #1;
        checks++; if (mst_aw_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_awvalid got=%b exp=1", mst_aw_valid); end
        checks++; if (mst_w_valid !== 1'b1) begin errors++; $display("FAIL reset_pre_wvalid got=%b exp=1", mst_w_valid); end
        rst = 1'b1;
        #1;
        checks++; if (mst_aw_valid !== 1'b0) begin errors++; $display("FAIL reset_awvalid got=%b exp=0", mst_aw_valid); end
        checks++; if (mst_w_valid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got=%b exp=0", mst_w_valid); end
        checks++; if (slv_aw_ready !== 4'b0000) begin errors++; $display("FAIL reset_awready got=%b exp=0000", slv_aw_ready); end
        checks++; if (slv_w_ready !== 4'b0000) begin errors++; $display("FAIL reset_wready got=%b exp=0000", slv_w_ready); end
        checks++; if (slv_b_valid !== 4'b0000) begin errors++; $display("FAIL reset_bvalid got=%b exp=0000", slv_b_valid); end
        checks++; if (mst_b_ready !== 1'b0) begin errors++; $display("FAIL reset_bready got=%b exp=0", mst_b_ready); end
        nxt();
        rst = 1'b0;
        idle_inputs();
        slv_aw_valid = 4'b1111;
        #1;
        checks++; if (slv_aw_ready !== 4'b0001) begin errors++; $display("FAIL reset_rr_ptr0 aw_ready=%b exp=%b", slv_aw_ready, 4'b0001); end
        slv_aw_valid = 4'b1000;
        slv_aw_id[3] = 6'h2A;
        #1;
        checks++; if (slv_aw_ready !== 4'b1000) begin errors++; $display("FAIL reset_port3 aw_ready=%b exp=%b", slv_aw_ready, 4'b1000); end
        nxt();
        slv_aw_valid = '0;
        #1;
        checks++; if (mst_aw_valid !== 1'b1 || mst_aw_id !== {2'd3, 6'h2A}) begin errors++; $display("FAIL reset_port3_out valid=%b id=%h exp_id=%h", mst_aw_valid, mst_aw_id, {2'd3, 6'h2A}); end
        $display("test_reset done");
    endtask

    task automatic test_single_write();
        logic [DW-1:0] d;
        do_reset();
        slv_aw_valid[2] = 1'b1;
        slv_aw_id[2]    = 6'h05;
        slv_aw_addr[2]  = 64'h0000_0000_8000_0040;
        #1;
        checks++; if (slv_aw_ready !== 4'b0100) begin errors++; $display("FAIL single_aw_ready got=%b exp=%b", slv_aw_ready, 4'b0100); end
        nxt();
        slv_aw_valid = '0;
        #1;
        checks++; if (mst_aw_valid !== 1'b1) begin errors++; $display("FAIL single_aw_valid got=%b exp=1", mst_aw_valid); end
        checks++; if (mst_aw_id !== 8'h85) begin errors++; $display("FAIL single_aw_id got=%h exp=85", mst_aw_id); end
        checks++; if (mst_aw_addr !== 64'h0000_0000_8000_0040) begin errors++; $display("FAIL single_aw_addr got=%h exp=80000040", mst_aw_addr); end
        for (int b = 0; b < 4; b++) begin
            d = {$urandom, $urandom};
            slv_w_valid[2] = 1'b1;
            slv_w_data[2]  = d;
            slv_w_last[2]  = (b == 3);
            #1;
            checks++; if (mst_w_valid !== 1'b1 || mst_w_data !== d || mst_w_last !== (b == 3)) begin errors++; $display("FAIL single_w_beat%0d valid=%b data=%h last=%b exp_data=%h", b, mst_w_valid, mst_w_data, mst_w_last, d); end
            checks++; if (slv_w_ready !== 4'b0100) begin errors++; $display("FAIL single_w_ready%0d got=%b exp=%b", b, slv_w_ready, 4'b0100); end
            $display("single write beat %0d data %h", b, d);
            nxt();
        end
        slv_w_last[2] = 1'b0;
        #1;
        checks++; if (mst_w_valid !== 1'b0) begin errors++; $display("FAIL single_fifo_empty wvalid=%b exp=0", mst_w_valid); end
        slv_w_valid = '0;
    endtask

    task automatic test_fairness();
        do_reset();
        slv_aw_valid = 4'b1111;
        slv_w_valid  = 4'b1111;
        slv_w_last   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (slv_aw_ready !== (4'b0001 << (k % NP))) begin errors++; $display("FAIL fair_grant%0d got=%b exp=%b", k, slv_aw_ready, 4'b0001 << (k % NP)); end
            nxt();
        end
        $display("test_fairness done");
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        do_reset();
        slv_aw_valid[0] = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            #1;
            checks++; if (slv_aw_ready !== 4'b0001) begin errors++; $display("FAIL full_fill%0d got=%b exp=0001", k, slv_aw_ready); end
            nxt();
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (slv_aw_ready !== 4'b0000) begin errors++; $display("FAIL full_block%0d got=%b exp=0000", k, slv_aw_ready); end
            nxt();
        end
        slv_w_valid[0] = 1'b1;
        slv_w_last[0]  = 1'b1;
        #1;
        checks++; if (slv_w_ready !== 4'b0001) begin errors++; $display("FAIL full_pop_wready got=%b exp=0001", slv_w_ready); end
        checks++; if (slv_aw_ready !== 4'b0000) begin errors++; $display("FAIL full_pop_cycle got=%b exp=0000", slv_aw_ready); end
        nxt();
        slv_w_valid = '0;
        #1;
        checks++; if (slv_aw_ready !== 4'b0001) begin errors++; $display("FAIL full_after_pop got=%b exp=0001", slv_aw_ready); end
        nxt();
        $display("test_fifo_full done");
        idle_inputs();
    endtask

    task automatic test_w_order();
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        do_reset();
        slv_aw_valid = 4'b0010;
        #1;
        checks++; if (slv_aw_ready !== 4'b0010) begin errors++; $display("FAIL order_aw1 got=%b exp=0010", slv_aw_ready); end
        nxt();
        slv_aw_valid = 4'b0001;
        #1;
        checks++; if (slv_aw_ready !== 4'b0001) begin errors++; $display("FAIL order_aw0 got=%b exp=0001", slv_aw_ready); end
        nxt();
        slv_aw_valid   = '0;
        d0             = {$urandom, $urandom};
        slv_w_valid[0] = 1'b1;
        slv_w_last[0]  = 1'b1;
        slv_w_data[0]  = d0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (slv_w_ready[0] !== 1'b0 || mst_w_valid !== 1'b0) begin errors++; $display("FAIL order_stall%0d wready0=%b mwvalid=%b exp=0,0", k, slv_w_ready[0], mst_w_valid); end
            nxt();
        end
        slv_w_valid[1] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            d1            = {$urandom, $urandom};
            slv_w_data[1] = d1;
            slv_w_last[1] = (b == 1);
            #1;
            checks++; if (slv_w_ready !== 4'b0010 || mst_w_data !== d1) begin errors++; $display("FAIL order_p1_beat%0d wready=%b data=%h exp=0010 %h", b, slv_w_ready, mst_w_data, d1); end
            nxt();
        end
        slv_w_valid[1] = 1'b0;
        #1;
        checks++; if (slv_w_ready !== 4'b0001 || mst_w_data !== d0 || mst_w_valid !== 1'b1) begin errors++; $display("FAIL order_p0 wready=%b data=%h valid=%b exp=0001 %h 1", slv_w_ready, mst_w_data, mst_w_valid, d0); end
        nxt();
        $display("test_w_order done");
        idle_inputs();
    endtask

    task automatic test_b_routing();
        int idx;
        logic [IDW-1:0] lid;
        logic [NP-1:0] rv;
        logic bv;
        idle_inputs();
        mst_b_valid = 1'b1;
        mst_b_id    = 8'hC3;
        slv_b_ready = 4'b0111;
        #1;
        checks++; if (slv_b_valid !== 4'b1000) begin errors++; $display("FAIL b_c3_valid got=%b exp=1000", slv_b_valid); end
        checks++; if (slv_b_id !== 6'h03) begin errors++; $display("FAIL b_c3_id got=%h exp=03", slv_b_id); end
        checks++; if (mst_b_ready !== 1'b0) begin errors++; $display("FAIL b_c3_ready got=%b exp=0", mst_b_ready); end
        slv_b_ready = 4'b1000;
        #1;
        checks++; if (mst_b_ready !== 1'b1) begin errors++; $display("FAIL b_c3_ready1 got=%b exp=1", mst_b_ready); end
        for (int n = 0; n < 16; n++) begin
            idx = $urandom_range(0, NP - 1);
            lid = IDW'($urandom);
            rv  = NP'($urandom);
            bv  = 1'($urandom);
            mst_b_valid = bv;
            mst_b_id    = (MIDW'(idx) << IDW) | MIDW'(lid);
            slv_b_ready = rv;
            #1;
            checks++; if (slv_b_valid !== (bv ? (4'b0001 << idx) : 4'b0000) || slv_b_id !== lid || mst_b_ready !== rv[idx]) begin errors++; $display("FAIL b_rand%0d valid=%b id=%h ready=%b port=%0d exp_id=%h exp_ready=%b", n, slv_b_valid, slv_b_id, mst_b_ready, idx, lid, rv[idx]); end
        end
        $display("test_b_routing done");
        idle_inputs();
    endtask

    task automatic test_random();
        aw_t   out_q[$];
        beat_t exp_w[$];
        aw_t   a;
        beat_t bt;
        int ptr;
        int outstanding;
        int win;
        int q;
        int head;
        int nb;
        logic [NP-1:0] exp_aw_rdy;
        logic [NP-1:0] exp_w_rdy;
        logic [NP-1:0] clr_aw;
        logic [NP-1:0] clr_w;
        logic exp_wv;
        do_reset();
        ptr = 0;
        outstanding = 0;
        clr_aw = '0;
        clr_w = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            slv_aw_valid = slv_aw_valid & ~clr_aw;
            slv_w_valid  = slv_w_valid & ~clr_w;
            clr_aw = '0;
            clr_w  = '0;
            for (int p = 0; p < NP; p++) begin
                if (!slv_aw_valid[p] && $urandom_range(0, 2) == 0) begin
                    slv_aw_valid[p] = 1'b1;
                    slv_aw_id[p]    = IDW'($urandom);
                    slv_aw_addr[p]  = {$urandom, $urandom};
                end
                if (!slv_w_valid[p] && $urandom_range(0, 3) != 0) begin
                    for (int j = exp_w.size() - 1; j >= 0; j--) begin
                        if (int'(exp_w[j].port) == p) begin
                            slv_w_data[p] = exp_w[j].data;
                            slv_w_last[p] = exp_w[j].last;
                            slv_w_valid[p] = 1'b1;
                        end
                    end
                end
            end
            mst_aw_ready = ($urandom_range(0, 3) != 0);
            mst_w_ready  = ($urandom_range(0, 3) != 0);
            #1;
            win = -1;
            for (int k = 0; k < NP; k++) begin
                q = (ptr + k) % NP;
                if (win < 0 && slv_aw_valid[q]) win = q;
            end
            exp_aw_rdy = '0;
            if (win >= 0 && (out_q.size() == 0 || mst_aw_ready) && outstanding < DEPTH) exp_aw_rdy[win] = 1'b1;
            head = (exp_w.size() > 0) ? int'(exp_w[0].port) : 0;
            exp_wv = (outstanding > 0) && slv_w_valid[head];
            exp_w_rdy = (outstanding > 0 && mst_w_ready) ? (4'b0001 << head) : 4'b0000;
            checks++; if (slv_aw_ready !== exp_aw_rdy) begin errors++; $display("FAIL rand_aw_ready cyc%0d got=%b exp=%b", cyc, slv_aw_ready, exp_aw_rdy); end
            checks++; if (mst_aw_valid !== (out_q.size() > 0)) begin errors++; $display("FAIL rand_aw_valid cyc%0d got=%b exp=%b", cyc, mst_aw_valid, out_q.size() > 0); end
            if (out_q.size() > 0) begin
                checks++; if (mst_aw_id !== {out_q[0].port, out_q[0].id} || mst_aw_addr !== out_q[0].addr) begin errors++; $display("FAIL rand_aw_payload cyc%0d id=%h addr=%h exp=%h %h", cyc, mst_aw_id, mst_aw_addr, {out_q[0].port, out_q[0].id}, out_q[0].addr); end
            end
            checks++; if (mst_w_valid !== exp_wv || slv_w_ready !== exp_w_rdy) begin errors++; $display("FAIL rand_w_hs cyc%0d wvalid=%b wready=%b exp=%b %b", cyc, mst_w_valid, slv_w_ready, exp_wv, exp_w_rdy); end
            if (exp_wv) begin
                checks++; if (mst_w_data !== exp_w[0].data || mst_w_last !== exp_w[0].last) begin errors++; $display("FAIL rand_w_beat cyc%0d data=%h last=%b exp=%h %b", cyc, mst_w_data, mst_w_last, exp_w[0].data, exp_w[0].last); end
            end
            if (out_q.size() > 0 && mst_aw_ready) void'(out_q.pop_front());
            if (exp_wv && mst_w_ready) begin
                bt = exp_w.pop_front();
                clr_w[bt.port] = 1'b1;
                if (bt.last) outstanding--;
            end
            if (exp_aw_rdy != '0) begin
                a.port = PIW'(win);
                a.id   = slv_aw_id[win];
                a.addr = slv_aw_addr[win];
                out_q.push_back(a);
                clr_aw[win] = 1'b1;
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++) begin
                    bt.port = PIW'(win);
                    bt.last = (b == nb - 1);
                    bt.data = {$urandom, $urandom};
                    exp_w.push_back(bt);
                end
                outstanding++;
                ptr = (win + 1) % NP;
                $display("aw accept cyc %0d port %0d id %h addr %h beats %0d", cyc, win, a.id, a.addr, nb);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_fairness();
        test_fifo_full();
        test_w_order();
        test_b_routing();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
